// File: rtl/seq_rem_div.sv
// rtl/seq_rem_div.sv - multi-cycle signed-magnitude divider returning remainder and quotient
module seq_rem_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             divbyzero,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int M  = WIDTH - 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(M - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  dvd;       // dividend bits still to consume; quotient bits shift in at the LSB
  logic [M-1:0]  dvs;       // divisor magnitude
  logic [M:0]    prem;      // partial remainder, one bit wider than the divisor
  logic          sn, sd;    // operand signs
  logic [CW-1:0] cnt;

  logic          den_zero;
  logic [M+1:0]  shifted;
  logic [M+1:0]  trial;
  logic          qbit;
  logic [M:0]    prem_nxt;
  logic [M-1:0]  qmag;
  logic [M-1:0]  rmag;

  assign den_zero = (denominator[M-1:0] == '0);
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only honoured outside CALC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = den_zero ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (cnt == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring-division step: shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    shifted  = {prem, dvd[M-1]};
    trial    = shifted - {2'b00, dvs};
    qbit     = ~trial[M+1];
    prem_nxt = qbit ? trial[M:0] : shifted[M:0];
    qmag     = {dvd[M-2:0], qbit};
    rmag     = prem_nxt[M-1:0];
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      sn        <= 1'b0;
      sd        <= 1'b0;
      cnt       <= '0;
      remainder <= '0;
      quotient  <= '0;
      divbyzero <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (den_zero) begin
              remainder <= '0;
              quotient  <= '0;
              divbyzero <= 1'b1;
              zero      <= 1'b0;
            end else begin
              dvd  <= numerator[M-1:0];
              dvs  <= denominator[M-1:0];
              sn   <= numerator[M];
              sd   <= denominator[M];
              prem <= '0;
              cnt  <= CNT_INIT;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dvd  <= qmag;
          if (cnt == '0) begin
            // Signs are dropped on zero magnitudes so -0 never appears
            remainder <= {sn & (|rmag), rmag};
            quotient  <= {(sn ^ sd) & (|qmag), qmag};
            zero      <= (rmag == '0);
            divbyzero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_rem_div.sv
// tb/tb_seq_rem_div.sv - directed self-checking bench for seq_rem_div at WIDTH 4 and 8
module tb_seq_rem_div;

  logic       clk;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] num4, den4, rem4, quot4;
  logic [7:0] num8, den8, rem8, quot8;
  logic       dbz4, zero4, busy4, done4;
  logic       dbz8, zero8, busy8, done8;

  int checks = 0;
  int errors = 0;

  seq_rem_div #(.WIDTH(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .numerator(num4), .denominator(den4),
    .remainder(rem4), .quotient(quot4),
    .divbyzero(dbz4), .zero(zero4), .busy(busy4), .done(done4)
  );

  seq_rem_div #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .numerator(num8), .denominator(den8),
    .remainder(rem8), .quotient(quot8),
    .divbyzero(dbz8), .zero(zero8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, count edges from the accepting edge (inclusive) to done,
  // optionally pulse a stray start mid-CALC, then check timing and results.
  task automatic run_div(input bit w8, input logic [7:0] n, input logic [7:0] d,
                         input logic [7:0] er, input logic [7:0] eq,
                         input logic ez, input logic edbz,
                         input int elat, input int ebusy, input bit mid, input string tag);
    int lat;
    int nbusy;
    if (w8) begin start8 = 1'b1; num8 = n; den8 = d; end
    else    begin start4 = 1'b1; num4 = n[3:0]; den4 = d[3:0]; end
    tick();
    start4 = 1'b0;
    start8 = 1'b0;
    lat    = 1;
    nbusy  = 0;
    while (!(w8 ? done8 : done4) && lat < 40) begin
      if (w8 ? busy8 : busy4) nbusy++;
      if (mid && lat == 3) begin
        start8 = 1'b1; num8 = 8'd50; den8 = 8'd3;
      end else begin
        start8 = 1'b0;
      end
      tick();
      lat++;
    end
    start8 = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(ebusy));
    check({tag, " remainder"}, 32'(w8 ? rem8 : {4'b0, rem4}), 32'(er));
    check({tag, " quotient"}, 32'(w8 ? quot8 : {4'b0, quot4}), 32'(eq));
    check({tag, " zero"}, 32'(w8 ? zero8 : zero4), 32'(ez));
    check({tag, " divbyzero"}, 32'(w8 ? dbz8 : dbz4), 32'(edbz));
  endtask

  initial begin
    int quiet;
    rst_n  = 1'b0;
    start4 = 1'b1;
    start8 = 1'b1;
    num4 = 4'd7;  den4 = 4'd3;
    num8 = 8'd7;  den8 = 8'd3;
    tick();
    tick();
    check("rst busy4", 32'(busy4), 32'd0);
    check("rst done4", 32'(done4), 32'd0);
    check("rst rem4", 32'(rem4), 32'd0);
    check("rst quot4", 32'(quot4), 32'd0);
    check("rst flags4", 32'({dbz4, zero4}), 32'd0);
    check("rst busy8", 32'(busy8), 32'd0);
    check("rst done8", 32'(done8), 32'd0);
    check("rst out8", 32'({rem8, quot8, dbz8, zero8}), 32'd0);
    start4 = 1'b0;
    start8 = 1'b0;
    rst_n  = 1'b1;
    tick();

    // WIDTH=4: done 4 edges counting the accepting edge, busy 3 cycles
    run_div(1'b0, 8'b0111, 8'b0011, 8'b0001, 8'b0010, 1'b0, 1'b0, 4, 3, 1'b0, "p7/p3");
    tick();
    check("done pulse width", 32'(done4), 32'd0);
    check("idle after done", 32'(busy4), 32'd0);
    run_div(1'b0, 8'b1111, 8'b0011, 8'b1001, 8'b1010, 1'b0, 1'b0, 4, 3, 1'b0, "m7/p3");
    run_div(1'b0, 8'b1110, 8'b1011, 8'b0000, 8'b0010, 1'b1, 1'b0, 4, 3, 1'b0, "m6/m3");
    run_div(1'b0, 8'b0101, 8'b1000, 8'b0000, 8'b0000, 1'b0, 1'b1, 1, 0, 1'b0, "p5/m0");
    run_div(1'b0, 8'b0000, 8'b0011, 8'b0000, 8'b0000, 1'b1, 1'b0, 4, 3, 1'b0, "p0/p3");
    run_div(1'b0, 8'b1001, 8'b0111, 8'b1001, 8'b0000, 1'b0, 1'b0, 4, 3, 1'b0, "m1/p7");
    run_div(1'b0, 8'b0111, 8'b0001, 8'b0000, 8'b0111, 1'b1, 1'b0, 4, 3, 1'b0, "p7/p1");

    // WIDTH=8: 127/10, with a stray start mid-CALC, then back-to-back issue
    run_div(1'b1, 8'd127, 8'd10, 8'd7, 8'd12, 1'b0, 1'b0, 8, 7, 1'b0, "w8 127/10");
    run_div(1'b1, 8'h80 | 8'd100, 8'd7, 8'h82, 8'h8E, 1'b0, 1'b0, 8, 7, 1'b0, "w8 m100/p7");
    run_div(1'b1, 8'd127, 8'd10, 8'd7, 8'd12, 1'b0, 1'b0, 8, 7, 1'b1, "w8 stray start");
    check("b2b done before reissue", 32'(done8), 32'd1);
    run_div(1'b1, 8'd100, 8'd9, 8'd1, 8'd11, 1'b0, 1'b0, 8, 7, 1'b0, "w8 back-to-back");

    // Reset after two CALC cycles of a WIDTH=4 divide
    run_div(1'b0, 8'b0111, 8'b0011, 8'b0001, 8'b0010, 1'b0, 1'b0, 4, 3, 1'b0, "pre-reset");
    tick();
    start4 = 1'b1; num4 = 4'b0111; den4 = 4'b0011;
    tick();
    start4 = 1'b0;
    tick();
    check("mid busy before reset", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid rst busy", 32'(busy4), 32'd0);
    check("mid rst done", 32'(done4), 32'd0);
    check("mid rst outputs", 32'({rem4, quot4, dbz4, zero4}), 32'd0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done4 || busy4) quiet++;
    end
    check("no done after reset", 32'(quiet), 32'd0);
    run_div(1'b0, 8'b0101, 8'b0010, 8'b0001, 8'b0010, 1'b0, 1'b0, 4, 3, 1'b0, "p5/p2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rem_div.md
# seq_rem_div

Parametrised, multi-cycle signed-magnitude divider that returns both remainder and quotient for WIDTH-bit operands. It is the sequential, width-generic successor to the fixed 3-bit combinational remainder unit in the arithmetic datapath. It uses a start/done handshake, so the ALU controller can issue an operation and collect the registered result several cycles later. It keeps the existing divide-by-zero and zero-result flag semantics.

## Interface
Parameters:
- WIDTH, default 4: total operand/result width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude (M = WIDTH-1, legal M >= 2).

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only while busy=0.
- numerator  in  WIDTH  signed-magnitude dividend; sampled on the accepting edge.
- denominator  in  WIDTH  signed-magnitude divisor; sampled on the accepting edge.
- remainder  out  WIDTH  signed-magnitude remainder, registered.
- quotient  out  WIDTH  signed-magnitude quotient, registered.
- divbyzero  out  1  denominator magnitude was 0.
- zero  out  1  remainder magnitude is 0 (valid divide only).
- busy  out  1  operation in progress; start ignored.
- done  out  1  one-cycle pulse; results valid from this cycle.

## Operation
- States: IDLE, CALC, DONE. Reset (rst_n=0 at an edge) forces IDLE. It also clears remainder, quotient, divbyzero, zero, busy, done and the bit counter, and overrides any in-flight operation.
- Transitions from IDLE or DONE when start=1:
  - If denominator[WIDTH-2:0]==0, go to DONE.
  - Otherwise, go to CALC. Load the magnitudes, load the signs, clear the partial remainder, set counter = M-1 and raise busy.
- Transitions from IDLE or DONE when start=0:
  - IDLE stays in IDLE.
  - DONE goes to IDLE.
- CALC does one restoring-division step per cycle on unsigned magnitudes:
  - Shift the partial remainder left, taking in the next dividend MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
  - When counter==0, go to DONE; otherwise decrement the counter.
  - The partial remainder register is M+1 bits wide, so the trial subtract never overflows.
- On entry to DONE, result registers are written and held until the next accepted start or reset.
- Valid divide result:
  - remainder magnitude = |N| mod |D|.
  - remainder sign = numerator sign, forced to 0 when the magnitude is 0 (no -0 output).
  - quotient magnitude = |N| div |D|.
  - quotient sign = XOR of the operand signs, forced to 0 when the magnitude is 0.
  - zero = (remainder magnitude == 0).
  - divbyzero = 0.
- Divide-by-zero (+0 or -0 divisor): remainder = 0, quotient = 0, divbyzero = 1, zero = 0.
- A zero numerator with a nonzero divisor is a normal divide: all results 0, zero = 1.
- start while busy=1 is ignored, with no queueing.
- start is accepted in the DONE cycle, giving back-to-back operations.
- done=1 exactly in DONE. busy=1 exactly in CALC.

## Timing
- Accepting edge = the rising edge at which start=1 and busy=0.
- Valid divide: busy is high for M cycles. done and the results appear M+1 edges after the accepting edge.
- Divide-by-zero: done and results appear 1 edge after the accepting edge, with no CALC cycles.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Back-to-back issue rate is one operation per M+1 cycles.
- Reset mid-CALC: the next cycle shows IDLE with all outputs 0, and no done pulse is produced.

## Test plan
- Reset: WIDTH=4, hold rst_n=0 for 2 edges with start=1 -> all outputs 0, busy=0, no done.
- Basic divide: WIDTH=4, N=4'b0111 (+7), D=4'b0011 (+3), start for 1 cycle -> busy for 3 cycles; done on edge 4 with remainder=4'b0001, quotient=4'b0010, zero=0, divbyzero=0.
- Signs:
  - N=-7 (4'b1111), D=+3 -> remainder=4'b1001, quotient=4'b1010.
  - N=-6 (4'b1110), D=-3 (4'b1011) -> remainder=4'b0000 (sign cleared), quotient=4'b0010, zero=1.
- Divide-by-zero: D=4'b1000 (-0), N=+5 -> done 1 edge after acceptance, remainder=0, quotient=0, divbyzero=1, zero=0.
- Handshake:
  - WIDTH=8, N=+127, D=+10 -> done 8 edges after acceptance, remainder=8'd7, quotient=8'd12.
  - A second start pulsed mid-CALC is ignored and the results are unchanged.
  - A start during the DONE cycle is accepted and yields the next result 8 edges later.
- Reset mid-operation: WIDTH=4, pull rst_n low after 2 CALC cycles -> next cycle shows IDLE with outputs 0. A subsequent start with +5/+2 gives remainder=4'b0001, quotient=4'b0010.
